instruction_memory: RTL and testbench

- Responder side of the instruction fetch interface. Returns `inst_data` combinationally for the `inst_addr` driven by the fetch stage.
- Owns a word-addressed program RAM.
- Provides a streaming program-load port: valid/ready handshake, auto-incrementing address.
- Gates the core through `core_en` so the fetch stage never reads a partially written program.

---
 rtl/instruction_memory_pkg.sv | 14 +
 rtl/instruction_memory_if.sv | 31 +++
 rtl/instruction_memory_loader.sv | 95 +++++++++
 rtl/instruction_memory.sv | 75 +++++++
 tb/tb_instruction_memory.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared constants and types for the instruction memory and its program loader.
// IMEM_NOP is the word returned whenever the core must not see real program data.
package instruction_memory_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } imemState_e;

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch and program-load signals between the core/loader host (master) and the
// instruction memory (slave).
interface instruction_memory_if #(
    parameter int DEPTH_WORDS = 1024
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_fault;
    logic        core_en;

    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_len;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_ready;
    logic          load_done;

    modport master (
        output inst_addr, load_start, load_base, load_len, load_valid, load_data,
        input  inst_data, inst_fault, core_en, load_ready, load_done
    );

    modport slave (
        input  inst_addr, load_start, load_base, load_len, load_valid, load_data,
        output inst_data, inst_fault, core_en, load_ready, load_done
    );

endinterface

// File: rtl/instruction_memory_loader.sv
// Program-load sequencer: owns the IDLE/LOAD/DONE/RUN state, the auto-incrementing
// write address and the remaining-word count, and gates the core while loading.
module instruction_memory_loader
    import instruction_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter bit BOOT_RUN    = 1'b0,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load_start,
    input  logic [AW-1:0] i_load_base,
    input  logic [AW:0]   i_load_len,
    input  logic          i_load_valid,
    output logic          o_load_ready,
    output logic          o_load_done,
    output logic          o_core_en,
    output logic          o_we,
    output logic [AW-1:0] o_waddr
);

    localparam imemState_e  RESET_STATE = BOOT_RUN ? RUN : IDLE;
    localparam logic [AW:0] MAX_LEN     = DEPTH_WORDS[AW:0];
    localparam logic [AW:0] LAST_WORD   = {{AW{1'b0}}, 1'b1};

    imemState_e    r_state;
    imemState_e    w_state_next;
    logic [AW-1:0] r_word;
    logic [AW-1:0] w_word_next;
    logic [AW:0]   r_remaining;
    logic [AW:0]   w_remaining_next;
    logic [AW:0]   w_len_clamped;
    logic          w_xfer;

    assign w_len_clamped = (i_load_len > MAX_LEN) ? MAX_LEN : i_load_len;
    assign w_xfer        = i_load_valid && (r_state == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RESET_STATE;
            r_word      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_next;
            r_word      <= w_word_next;
            r_remaining <= w_remaining_next;
        end
    end

    // Starts are only honoured from IDLE or RUN; LOAD and DONE ignore them.
    always_comb begin
        w_state_next     = r_state;
        w_word_next      = r_word;
        w_remaining_next = r_remaining;
        unique case (r_state)
            IDLE, RUN: begin
                if (i_load_start) begin
                    if (i_load_len == '0) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next     = LOAD;
                        w_word_next      = i_load_base;
                        w_remaining_next = w_len_clamped;
                    end
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    // Address wraps naturally because DEPTH_WORDS is a power of two.
                    w_word_next      = r_word + 1'b1;
                    w_remaining_next = r_remaining - 1'b1;
                    if (r_remaining == LAST_WORD) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RESET_STATE;
            end
        endcase
    end

    always_comb begin
        o_load_ready = (r_state == LOAD);
        o_load_done  = (r_state == DONE);
        o_core_en    = (r_state == RUN);
        o_we         = w_xfer;
        o_waddr      = r_word;
    end

endmodule

// File: rtl/instruction_memory.sv
// Word-addressed program RAM with a zero-latency fetch read port and a streaming
// load port; fetch only sees real words while the loader reports RUN.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter bit BOOT_RUN    = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_memory_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   r_ram [DEPTH_WORDS];
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic          w_core_en;
    logic [AW-1:0] w_word_idx;
    logic          w_misaligned;
    logic          w_out_of_range;
    logic          w_fault;
    logic [31:0]   w_rdata;

    instruction_memory_loader #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BOOT_RUN    (BOOT_RUN)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_start (bus.load_start),
        .i_load_base  (bus.load_base),
        .i_load_len   (bus.load_len),
        .i_load_valid (bus.load_valid),
        .o_load_ready (bus.load_ready),
        .o_load_done  (bus.load_done),
        .o_core_en    (w_core_en),
        .o_we         (w_we),
        .o_waddr      (w_waddr)
    );

    // Contents survive reset so a program written before a reset stays readable.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= bus.load_data;
        end
    end

    assign w_word_idx   = bus.inst_addr[AW+1:2];
    assign w_misaligned = (bus.inst_addr[1:0] != 2'b00);

    generate
        if (AW + 2 < 32) begin : g_range_check
            assign w_out_of_range = |bus.inst_addr[31:AW+2];
        end else begin : g_full_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_fault = w_misaligned || w_out_of_range;

    // Fetch samples inst_data on the same edge it advances pc, so no register here.
    always_comb begin
        w_rdata = IMEM_NOP;
        if (!w_fault && w_core_en) begin
            w_rdata = r_ram[w_word_idx];
        end
    end

    assign bus.inst_data  = w_rdata;
    assign bus.inst_fault = w_fault;
    assign bus.core_en    = w_core_en;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed-plus-random bench for instruction_memory: loads random programs and
// compares every fetch against an array model of what was written.
module tb_instruction_memory;

    localparam int          D   = 1024;
    localparam int          AW  = $clog2(D);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] mem_model [D];
    bit          known     [D];

    instruction_memory_if #(.DEPTH_WORDS(D)) bus ();

    instruction_memory #(
        .DEPTH_WORDS (D),
        .BOOT_RUN    (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected fetch result follows directly from the address rules and the model.
    task automatic check_read(input logic [31:0] addr, input bit in_run);
        bit          exp_fault;
        int          widx;
        bus.inst_addr = addr;
        #1;
        exp_fault = (addr[1:0] != 2'b00) || (addr >= 32'(4 * D));
        widx      = int'(addr >> 2);
        check1("inst_fault", bus.inst_fault, exp_fault);
        if (exp_fault || !in_run) begin
            check32("inst_data_nop", bus.inst_data, NOP);
        end else if (known[widx]) begin
            check32("inst_data", bus.inst_data, mem_model[widx]);
        end
        $display("read addr=%h fault=%b data=%h", addr, bus.inst_fault, bus.inst_data);
    endtask

    task automatic sweep_known();
        for (int w = 0; w < D; w++) begin
            if (known[w]) check_read(32'(w * 4), 1'b1);
        end
    endtask

    // Streams a random program; optional stall and a stray start inside LOAD.
    task automatic do_load(input int base, input int len, input int stall_at,
                           input int stall_cycles, input int restart_at);
        int          eff;
        int          nbase;
        logic [31:0] word;
        eff   = (len > D) ? D : len;
        nbase = (base + 100) % D;
        bus.load_base  = base[AW-1:0];
        bus.load_len   = len[AW:0];
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check1("start_core_en", bus.core_en, 1'b0);
        if (eff == 0) begin
            check1("zero_done", bus.load_done, 1'b1);
            check1("zero_ready", bus.load_ready, 1'b0);
            tick();
            check1("zero_core_en_back", bus.core_en, 1'b1);
            check1("zero_done_low", bus.load_done, 1'b0);
            $display("load base=%0d len=0 done", base);
            return;
        end
        for (int i = 0; i < eff; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    bus.load_valid = 1'b0;
                    check1("stall_ready", bus.load_ready, 1'b1);
                    check1("stall_done", bus.load_done, 1'b0);
                    tick();
                end
            end
            if (i == restart_at) begin
                bus.load_start = 1'b1;
                bus.load_base  = nbase[AW-1:0];
                bus.load_len   = 11'd7;
            end
            check1("load_ready", bus.load_ready, 1'b1);
            word           = $urandom;
            bus.load_valid = 1'b1;
            bus.load_data  = word;
            tick();
            bus.load_start = 1'b0;
            mem_model[(base + i) % D] = word;
            known[(base + i) % D]     = 1'b1;
        end
        bus.load_valid = 1'b0;
        check1("done_pulse", bus.load_done, 1'b1);
        check1("done_ready", bus.load_ready, 1'b0);
        check1("done_core_en", bus.core_en, 1'b0);
        tick();
        check1("after_done", bus.load_done, 1'b0);
        check1("run_core_en", bus.core_en, 1'b1);
        check1("run_ready", bus.load_ready, 1'b0);
        $display("load base=%0d len=%0d written=%0d done", base, len, eff);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] first_word;
        checks = 0;
        errors = 0;
        for (int w = 0; w < D; w++) known[w] = 1'b0;
        rst_n          = 1'b0;
        bus.inst_addr  = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        // Reset state
        tick();
        tick();
        check1("rst_core_en", bus.core_en, 1'b0);
        check1("rst_ready", bus.load_ready, 1'b0);
        check1("rst_done", bus.load_done, 1'b0);
        check32("rst_inst_data", bus.inst_data, NOP);
        rst_n = 1'b1;
        tick();
        check1("idle_core_en", bus.core_en, 1'b0);
        check_read(32'h0, 1'b0);

        // First program, back to back
        do_load(0, 3, -1, 0, -1);
        check_read(32'h0, 1'b1);
        check_read(32'h4, 1'b1);
        check_read(32'h8, 1'b1);

        // Filler then stalled load over part of it
        do_load(3, 8, -1, 0, -1);
        do_load(4, 2, 1, 5, -1);
        sweep_known();

        // Wrap across the top of memory
        do_load(D - 2, 4, -1, 0, -1);
        check_read(32'h0000_0FF8, 1'b1);
        check_read(32'h0000_0000, 1'b1);
        check32("wrap_third_word", mem_model[0], mem_model[0]);
        first_word = mem_model[D - 2];
        bus.inst_addr = 32'h0000_0FF8;
        #1;
        check32("wrap_first_word", bus.inst_data, first_word);

        // Fault checks in RUN
        check_read(32'h2, 1'b1);
        check_read(32'(4 * D), 1'b1);
        check_read(32'h4, 1'b1);
        for (int k = 0; k < 24; k++) begin
            addr = $urandom;
            if ($urandom_range(1) == 1) addr = addr & 32'h0000_1FFF;
            check_read(addr, 1'b1);
        end

        // Zero length and ignored start during LOAD
        tick();
        do_load(50, 0, -1, 0, -1);
        do_load(60, 3, -1, 0, 1);
        sweep_known();

        // Oversized length is clamped to the full depth
        do_load(7, 1500, -1, 0, -1);
        sweep_known();

        // Reset in the middle of a load
        tick();
        bus.load_base  = 10'd10;
        bus.load_len   = 11'd3;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = $urandom;
        first_word     = bus.load_data;
        tick();
        mem_model[10]  = first_word;
        bus.load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check1("midrst_core_en", bus.core_en, 1'b0);
        check1("midrst_ready", bus.load_ready, 1'b0);
        check_read(32'd40, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check1("postrst_core_en", bus.core_en, 1'b0);
        check1("postrst_ready", bus.load_ready, 1'b0);
        do_load(20, 1, -1, 0, -1);
        check_read(32'd40, 1'b1);
        check_read(32'd80, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
